clk_div_ratio_ctrl: RTL and testbench

Arbitrated reconfiguration controller for the integer clock divider. Two requesters (register file and power manager) ask for a new division ratio. The block grants one request at a time round-robin, gates the divider off for a settle window, loads the new ratio and re-enables it. It sits between the requesters and the divider's i_clk_en / i_div_ratio inputs, so that ratio changes never happen while the divider is running.

---
 rtl/clk_div_pkg.sv | 22 ++
 rtl/clk_div_ratio_ctrl_rr_arb2.sv | 46 ++++
 rtl/clk_div_ratio_ctrl.sv | 174 +++++++++++++++++
 tb/tb_clk_div_ratio_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_pkg
// Description : Shared types and constants for the divider ratio controller:
//               FSM state encoding, default ratio bus width and settle
//               counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

  localparam int C_RATIO_W  = 8;  // default width of every ratio bus
  localparam int C_SETTLE_W = 4;  // settle counter width, covers 1..15 cycles

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GATE = 2'd1,
    ST_LOAD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/clk_div_ratio_ctrl_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-requester round-robin arbiter. Grant is combinational
//               and one-hot; the priority pointer moves to the other
//               requester whenever a grant is consumed.
// Ports       : i_ref_clk  - clock
//               i_rst_n    - asynchronous active-low reset (pointer -> 0)
//               req[1:0]   - request lines
//               advance    - grant consumed this cycle, move the pointer
//               gnt[1:0]   - one-hot grant
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  logic       i_ref_clk,
  input  logic       i_rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // 0: requester 0 has priority, 1: requester 1 has priority
  logic r_ptr;

  always_comb begin
    gnt = 2'b00;
    if (!r_ptr) begin
      if (req[0])      gnt = 2'b01;
      else if (req[1]) gnt = 2'b10;
    end else begin
      if (req[1])      gnt = 2'b10;
      else if (req[0]) gnt = 2'b01;
    end
  end

  // After a grant, the requester that did not win gets priority.
  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= 1'b0;
    end else if (advance && (|gnt)) begin
      r_ptr <= ~gnt[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/clk_div_ratio_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_ratio_ctrl
// Description : Arbitrated reconfiguration controller for the integer clock
//               divider. Grants one ratio-change request at a time, holds
//               the divider disabled for a settle window, loads the new
//               ratio and re-enables the divider.
// Ports       : i_ref_clk   - reference clock
//               i_rst_n     - asynchronous active-low reset
//               i_enable    - global divider enable
//               i_req[1:0]  - level change requests, held until o_ack[n]
//               i_ratio0/1  - requested ratios
//               o_ack[1:0]  - one-cycle completion pulse
//               o_err[1:0]  - one-cycle rejection pulse (ratio 0)
//               o_div_ratio - registered ratio to the divider
//               o_clk_en    - registered enable to the divider
//               o_busy      - controller is not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_ratio_ctrl
  import clk_div_pkg::*;
#(
  parameter int                 RATIO_W       = C_RATIO_W,
  parameter int                 SETTLE_CYC    = 4,
  parameter logic [RATIO_W-1:0] DEFAULT_RATIO = 8'd2
) (
  input  logic               i_ref_clk,
  input  logic               i_rst_n,
  input  logic               i_enable,
  input  logic [1:0]         i_req,
  input  logic [RATIO_W-1:0] i_ratio0,
  input  logic [RATIO_W-1:0] i_ratio1,
  output logic [1:0]         o_ack,
  output logic [1:0]         o_err,
  output logic [RATIO_W-1:0] o_div_ratio,
  output logic               o_clk_en,
  output logic               o_busy
);

  localparam logic [C_SETTLE_W-1:0] C_SETTLE_LOAD = C_SETTLE_W'(SETTLE_CYC - 1);

  state_t                r_state, w_state_nxt;
  logic [C_SETTLE_W-1:0] r_cnt, w_cnt_nxt;
  logic [RATIO_W-1:0]    r_hold, w_hold_nxt;
  logic                  r_sel, w_sel_nxt;
  logic                  r_pend_ack, w_pend_ack_nxt;
  logic                  r_pend_err, w_pend_err_nxt;
  logic [1:0]            r_ack, w_ack_nxt;
  logic [1:0]            r_err, w_err_nxt;
  logic [RATIO_W-1:0]    r_div_ratio, w_div_ratio_nxt;
  logic                  r_clk_en, w_clk_en_nxt;

  logic [1:0]            w_sel_oh, w_mask, w_req_eff, w_gnt;
  logic                  w_take, w_reject, w_noop, w_change;
  logic [RATIO_W-1:0]    w_gnt_ratio;

  assign w_sel_oh = {r_sel, ~r_sel};

  // A reject/no-op answer is issued one cycle after capture. The requester
  // is still holding its request on that edge, so it is masked out to
  // avoid sampling the same request twice.
  assign w_mask    = (r_pend_ack | r_pend_err) ? w_sel_oh : 2'b00;
  assign w_req_eff = i_req & ~w_mask;

  rr_arb2 u_arb (
    .i_ref_clk (i_ref_clk),
    .i_rst_n   (i_rst_n),
    .req       (w_req_eff),
    .advance   (w_take),
    .gnt       (w_gnt)
  );

  assign w_take      = (r_state == ST_IDLE) && (|w_gnt);
  assign w_gnt_ratio = w_gnt[1] ? i_ratio1 : i_ratio0;
  assign w_reject    = w_take && (w_gnt_ratio == '0);
  assign w_noop      = w_take && !w_reject && (w_gnt_ratio == r_div_ratio);
  assign w_change    = w_take && !w_reject && !w_noop;

  // State register
  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_change) w_state_nxt = ST_GATE;
      ST_GATE: if (r_cnt == '0) w_state_nxt = ST_LOAD;
      ST_LOAD: w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    w_cnt_nxt       = r_cnt;
    w_hold_nxt      = r_hold;
    w_sel_nxt       = r_sel;
    w_pend_ack_nxt  = 1'b0;
    w_pend_err_nxt  = 1'b0;
    w_ack_nxt       = r_pend_ack ? w_sel_oh : 2'b00;
    w_err_nxt       = r_pend_err ? w_sel_oh : 2'b00;
    w_div_ratio_nxt = r_div_ratio;
    w_clk_en_nxt    = r_clk_en;
    case (r_state)
      ST_IDLE: begin
        w_clk_en_nxt = i_enable;
        if (w_take) begin
          w_hold_nxt = w_gnt_ratio;
          w_sel_nxt  = w_gnt[1];
          if (w_reject) begin
            w_pend_err_nxt = 1'b1;
          end else if (w_noop) begin
            w_pend_ack_nxt = 1'b1;
          end else begin
            w_clk_en_nxt = 1'b0;
            w_cnt_nxt    = C_SETTLE_LOAD;
          end
        end
      end
      ST_GATE: begin
        w_clk_en_nxt = 1'b0;
        if (r_cnt == '0) w_div_ratio_nxt = r_hold;  // load while disabled
        else             w_cnt_nxt       = r_cnt - 1'b1;
      end
      ST_LOAD: begin
        // Enable returns together with the ack, one cycle after the load.
        w_clk_en_nxt = i_enable;
        w_ack_nxt    = w_sel_oh;
      end
      ST_DONE: begin
        w_clk_en_nxt = i_enable;
      end
      default: begin
        w_clk_en_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt       <= '0;
      r_hold      <= DEFAULT_RATIO;
      r_sel       <= 1'b0;
      r_pend_ack  <= 1'b0;
      r_pend_err  <= 1'b0;
      r_ack       <= 2'b00;
      r_err       <= 2'b00;
      r_div_ratio <= DEFAULT_RATIO;
      r_clk_en    <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_hold      <= w_hold_nxt;
      r_sel       <= w_sel_nxt;
      r_pend_ack  <= w_pend_ack_nxt;
      r_pend_err  <= w_pend_err_nxt;
      r_ack       <= w_ack_nxt;
      r_err       <= w_err_nxt;
      r_div_ratio <= w_div_ratio_nxt;
      r_clk_en    <= w_clk_en_nxt;
    end
  end

  assign o_ack       = r_ack;
  assign o_err       = r_err;
  assign o_div_ratio = r_div_ratio;
  assign o_clk_en    = r_clk_en;
  assign o_busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_clk_div_ratio_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_ratio_ctrl
// Description : Scoreboard bench for clk_div_ratio_ctrl. Requesters push the
//               expected {ack, err, ratio} response into a queue; a monitor
//               pops and compares whenever an ack/err pulse appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_ratio_ctrl;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       req0, req1;
  logic [1:0] i_req;
  logic [7:0] ratio0, ratio1;
  logic [1:0] o_ack, o_err;
  logic [7:0] o_div_ratio;
  logic       o_clk_en, o_busy;

  int checks = 0;
  int errors = 0;

  // {ack[1:0], err[1:0], ratio[7:0]}
  logic [11:0] exp_q[$];

  assign i_req = {req1, req0};

  clk_div_ratio_ctrl dut (
    .i_ref_clk   (clk),
    .i_rst_n     (rst_n),
    .i_enable    (en),
    .i_req       (i_req),
    .i_ratio0    (ratio0),
    .i_ratio1    (ratio1),
    .o_ack       (o_ack),
    .o_err       (o_err),
    .o_div_ratio (o_div_ratio),
    .o_clk_en    (o_clk_en),
    .o_busy      (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every response pulse must match the head of the scoreboard.
  initial begin
    logic [11:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && ((|o_ack) || (|o_err))) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp got ack=%b err=%b ratio=%0d expected none",
                   o_ack, o_err, o_div_ratio);
        end else begin
          e = exp_q.pop_front();
          if ({o_ack, o_err, o_div_ratio} !== e) begin
            errors++;
            $display("FAIL resp got ack=%b err=%b ratio=%0d expected ack=%b err=%b ratio=%0d",
                     o_ack, o_err, o_div_ratio, e[11:10], e[9:8], e[7:0]);
          end
        end
      end
    end
  end

  // Raise request n, hold until its ack/err is seen, then drop it.
  task automatic requester(input int n, input logic [7:0] ratio);
    int t;
    @(negedge clk);
    if (n == 0) begin ratio0 = ratio; req0 = 1'b1; end
    else        begin ratio1 = ratio; req1 = 1'b1; end
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(o_ack[n] || o_err[n]) && t < 200);
    if (t >= 200) begin
      checks++;
      errors++;
      $display("FAIL timeout_req%0d got no response expected ack/err", n);
    end
    if (n == 0) req0 = 1'b0;
    else        req1 = 1'b0;
  endtask

  // Cycle-by-cycle view after the request is sampled (j = edges after k).
  task automatic watch(input string tag, input int n, input logic [7:0] en_exp,
                       input logic [7:0] busy_exp, input logic [7:0] r_old,
                       input logic [7:0] r_new, input int sw, input int resp_j);
    @(negedge clk);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      chk({tag, "_en"},    int'(o_clk_en), int'(en_exp[j]));
      chk({tag, "_busy"},  int'(o_busy),   int'(busy_exp[j]));
      chk({tag, "_ratio"}, int'(o_div_ratio), (j >= sw) ? int'(r_new) : int'(r_old));
      chk({tag, "_resp"},  int'((|o_ack) || (|o_err)), int'(j == resp_j));
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; req0 = 1'b0; req1 = 1'b0; ratio0 = '0; ratio1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_ratio", int'(o_div_ratio), 2);
    chk("rst_en",    int'(o_clk_en), 0);
    chk("rst_busy",  int'(o_busy), 0);
    chk("rst_resp",  int'({o_ack, o_err}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_en", int'(o_clk_en), 1);

    // Ratio change 2 -> 5
    exp_q.push_back({2'b01, 2'b00, 8'd5});
    fork
      requester(0, 8'd5);
      watch("chg", 7, 8'b0110_0000, 8'b0011_1111, 8'd2, 8'd5, 4, 5);
    join

    // Fresh reset so the pointer favours requester 0
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    exp_q.push_back({2'b01, 2'b00, 8'd3});
    exp_q.push_back({2'b10, 2'b00, 8'd7});
    fork
      requester(0, 8'd3);
      requester(1, 8'd7);
    join
    // No-op grant to requester 0 hands priority to requester 1
    exp_q.push_back({2'b01, 2'b00, 8'd7});
    requester(0, 8'd7);
    exp_q.push_back({2'b10, 2'b00, 8'd6});
    exp_q.push_back({2'b01, 2'b00, 8'd4});
    fork
      requester(0, 8'd4);
      requester(1, 8'd6);
    join

    // Reject ratio 0 on requester 1
    exp_q.push_back({2'b00, 2'b10, 8'd4});
    fork
      requester(1, 8'd0);
      watch("rej", 3, 8'h07, 8'h00, 8'd4, 8'd4, 0, 1);
    join

    // No-op: same ratio as current
    exp_q.push_back({2'b01, 2'b00, 8'd4});
    fork
      requester(0, 8'd4);
      watch("nop", 3, 8'h07, 8'h00, 8'd4, 8'd4, 0, 1);
    join

    // Global enable low: full sequence with o_clk_en held low
    en = 1'b0;
    @(negedge clk);
    exp_q.push_back({2'b01, 2'b00, 8'd9});
    fork
      requester(0, 8'd9);
      watch("dis", 7, 8'h00, 8'b0011_1111, 8'd4, 8'd9, 4, 5);
    join
    en = 1'b1;

    // Ratio 1 is accepted
    exp_q.push_back({2'b10, 2'b00, 8'd1});
    requester(1, 8'd1);

    // Reset while in GATE: in-flight request gets no ack
    @(negedge clk);
    ratio0 = 8'd8; req0 = 1'b1;
    repeat (2) @(negedge clk);
    chk("gate_busy", int'(o_busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ratio", int'(o_div_ratio), 2);
    chk("mid_rst_en",    int'(o_clk_en), 0);
    chk("mid_rst_busy",  int'(o_busy), 0);
    chk("mid_rst_resp",  int'({o_ack, o_err}), 0);
    req0 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_en", int'(o_clk_en), 1);
    exp_q.push_back({2'b01, 2'b00, 8'd8});
    fork
      requester(0, 8'd8);
      watch("reissue", 7, 8'b0110_0000, 8'b0011_1111, 8'd2, 8'd8, 4, 5);
    join

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
